async_fifo_wr_arbiter: RTL and testbench
========================================

Name: async_fifo_wr_arbiter

Overview:
- Shares the single write port of the async FIFO between NUM_REQ requesters in the write clock domain.
- Round-robin arbitration with burst locking. The FIFO's full flag gates every transfer.
- Drives the FIFO's wr_en_i / wdata_i directly and monitors its wr_error_o.
- Sits between the requester agents and the FIFO write side. No read-side logic.

Parameters:
- WIDTH, 8, data word width; must match the FIFO.
- NUM_REQ, 4, number of requesters (2..8).
- MAX_BURST, 4, maximum beats per grant before forced release (1..16).
- ERR_CNT_W, 16, width of the saturating write-error counter.

Ports:
- wr_clk_i  in  1  write-domain clock; all logic on its rising edge.
- rst_i  in  1  reset, asynchronous assert, active-low (0 = reset).
- req_valid_i  in  NUM_REQ  per-requester data valid.
- req_data_i  in  NUM_REQ*WIDTH  packed data; requester k uses bits [k*WIDTH +: WIDTH].
- req_last_i  in  NUM_REQ  marks the final beat of a requester's burst.
- req_ready_o  out  NUM_REQ  per-requester accept.
- full_i  in  1  FIFO full flag.
- wr_error_i  in  1  FIFO write-error flag.
- wr_en_o  out  1  FIFO write enable.
- wdata_o  out  WIDTH  FIFO write data.
- grant_o  out  NUM_REQ  registered one-hot grant; all zeros when idle.
- busy_o  out  1  high in LOCKED.
- err_cnt_o  out  ERR_CNT_W  count of cycles with wr_error_i high.
- err_clr_i  in  1  synchronous clear of err_cnt_o.

Behaviour:
- Reset values:
  - state IDLE; grant_o = 0; rr_ptr = 0; beat_cnt = 0; err_cnt_o = 0.
  - wr_en_o = 0 and req_ready_o = 0, since both are derived from grant_o = 0.
- FSM states IDLE, LOCKED.
- IDLE:
  - If any req_valid_i is high, pick the first valid index searching rr_ptr, rr_ptr+1, ... modulo NUM_REQ.
  - Register it into grant_o, clear beat_cnt, go to LOCKED.
  - Arbitration latency: 1 cycle from valid to grant; no transfer occurs in IDLE.
- LOCKED:
  - For granted index g: req_ready_o[g] = ~full_i (combinational). All other ready bits are 0.
  - Beat = req_valid_i[g] & req_ready_o[g].
  - wr_en_o = beat (combinational, zero latency); wdata_o = req_data_i[g] (muxed even when wr_en_o is 0).
  - Each beat increments beat_cnt.
  - Release when a beat occurs with req_last_i[g] = 1, or when the beat makes beat_cnt reach MAX_BURST.
  - On release: grant_o <- 0, rr_ptr <- (g+1) mod NUM_REQ, state <- IDLE. This costs one idle bubble before the next grant.
  - req_valid_i[g] dropping while LOCKED does not release the grant; it is held indefinitely.
- full_i high: no beat, and beat_cnt does not change. A write is never issued while full_i = 1, so wr_en_o & full_i is never 1.
- req_last_i is ignored on non-beat cycles.
- Error counter:
  - +1 on each cycle with wr_error_i = 1; saturates at all ones.
  - err_clr_i has priority over an increment on the same cycle; result is 0.
- Reset mid-burst: everything returns to reset values immediately (async). No partial-burst memory is kept.
- Invariants for the bench:
  - grant_o is always one-hot or zero.
  - At most one req_ready_o bit is high.
  - wr_en_o implies busy_o.

Decomposition:
- async_fifo_pkg holds the WIDTH default and an enum arb_state_e {IDLE, LOCKED}.
- One sub-module: rr_pick, combinational.
  - Inputs: req vector, rr_ptr.
  - Outputs: one-hot pick, any_req.
  - Reused by a later read-side scheduler.

Test Plan (NUM_REQ=4, WIDTH=8, MAX_BURST=4):
1. Reset: hold rst_i=0 with all req_valid_i=1 → grant_o=0, wr_en_o=0, err_cnt_o=0. Release reset; one cycle later grant_o=4'b0001.
2. Single burst: req0 sends 0x11, 0x22, 0x33 with last on 0x33, full_i=0 → three consecutive wr_en_o pulses with data 0x11/0x22/0x33, then one idle cycle and grant_o=0.
3. Round-robin and MAX_BURST: all four valid, never last → grants in order 0001, 0010, 0100, 1000, 0001. Each grant gets exactly 4 beats, with one bubble cycle between grants.
4. Back-pressure: req1 granted, full_i=1 for 3 cycles mid-burst → req_ready_o[1]=0 and wr_en_o=0 for those cycles; beat_cnt is held. Burst completes with the remaining beats after full_i drops, and no data is lost or duplicated.
5. Error counter: wr_error_i high for 5 cycles → err_cnt_o=5. Assert err_clr_i and wr_error_i on the same cycle → err_cnt_o=0. Force count to 0xFFFF plus one more error → stays 0xFFFF.
6. Reset mid-burst: req2 granted after 2 beats, rst_i=0 for 1 cycle → grant_o=0 immediately. After release, arbitration restarts from rr_ptr=0, so req0 wins if valid.

Source files
------------

// File: rtl/async_fifo_pkg.sv
// Shared types and defaults for the async FIFO write-side arbitration logic.
package async_fifo_pkg;
  localparam int WIDTH_DEF = 8;

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } arb_state_e;
endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set request at or after ptr, wrapping modulo N.
module rr_pick #(
  parameter int N  = 4,
  parameter int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  pick,
  output logic          any_req
);
  int   idx;
  logic found;

  always_comb begin
    pick  = '0;
    found = 1'b0;
    idx   = 0;
    for (int i = 0; i < N; i++) begin
      idx = (int'(ptr) + i) % N;
      if (!found && req[idx]) begin
        pick[idx] = 1'b1;
        found     = 1'b1;
      end
    end
  end

  assign any_req = |req;
endmodule

// File: rtl/async_fifo_wr_arbiter.sv
// Round-robin, burst-locking arbiter sharing the async FIFO write port between requesters.
// Handshake: a beat transfers when req_valid_i[g] & req_ready_o[g]; ready is ~full_i for the granted index only.
module async_fifo_wr_arbiter
  import async_fifo_pkg::*;
#(
  parameter int WIDTH     = WIDTH_DEF,
  parameter int NUM_REQ   = 4,
  parameter int MAX_BURST = 4,
  parameter int ERR_CNT_W = 16
) (
  input  logic                     wr_clk_i,
  input  logic                     rst_i,
  input  logic [NUM_REQ-1:0]       req_valid_i,
  input  logic [NUM_REQ*WIDTH-1:0] req_data_i,
  input  logic [NUM_REQ-1:0]       req_last_i,
  output logic [NUM_REQ-1:0]       req_ready_o,
  input  logic                     full_i,
  input  logic                     wr_error_i,
  output logic                     wr_en_o,
  output logic [WIDTH-1:0]         wdata_o,
  output logic [NUM_REQ-1:0]       grant_o,
  output logic                     busy_o,
  output logic [ERR_CNT_W-1:0]     err_cnt_o,
  input  logic                     err_clr_i
);
  localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int BW = $clog2(MAX_BURST + 1);
  localparam logic [BW-1:0] FINAL_BEAT = BW'(MAX_BURST - 1);
  localparam logic [PW-1:0] LAST_IDX   = PW'(NUM_REQ - 1);

  arb_state_e         state;
  logic [PW-1:0]      rr_ptr;
  logic [PW-1:0]      gidx;
  logic [PW-1:0]      pick_idx;
  logic [BW-1:0]      beat_cnt;
  logic [NUM_REQ-1:0] pick;
  logic               any_req;
  logic               beat;
  logic               last_beat;

  rr_pick #(
    .N  (NUM_REQ),
    .PW (PW)
  ) u_rr_pick (
    .req     (req_valid_i),
    .ptr     (rr_ptr),
    .pick    (pick),
    .any_req (any_req)
  );

  always_comb begin
    pick_idx = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (pick[i]) pick_idx = PW'(i);
    end
  end

  // grant_o is zero in IDLE, so ready and wr_en need no separate state qualifier.
  assign req_ready_o = grant_o & {NUM_REQ{~full_i}};
  assign beat        = |(req_valid_i & req_ready_o);
  assign wr_en_o     = beat;
  assign wdata_o     = req_data_i[int'(gidx)*WIDTH +: WIDTH];
  assign last_beat   = req_last_i[gidx];
  assign busy_o      = (state == LOCKED);

  always_ff @(posedge wr_clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state    <= IDLE;
      grant_o  <= '0;
      gidx     <= '0;
      rr_ptr   <= '0;
      beat_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (any_req) begin
            grant_o  <= pick;
            gidx     <= pick_idx;
            beat_cnt <= '0;
            state    <= LOCKED;
          end
        end
        LOCKED: begin
          if (beat) begin
            beat_cnt <= beat_cnt + 1'b1;
            if (last_beat || beat_cnt == FINAL_BEAT) begin
              grant_o <= '0;
              rr_ptr  <= (gidx == LAST_IDX) ? '0 : gidx + 1'b1;
              state   <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge wr_clk_i or negedge rst_i) begin
    if (!rst_i) begin
      err_cnt_o <= '0;
    end else if (err_clr_i) begin
      err_cnt_o <= '0;
    end else if (wr_error_i && err_cnt_o != '1) begin
      err_cnt_o <= err_cnt_o + 1'b1;
    end
  end
endmodule

// File: tb/tb_async_fifo_wr_arbiter.sv
// Directed bench for async_fifo_wr_arbiter with NUM_REQ=4, WIDTH=8, MAX_BURST=4.
module tb_async_fifo_wr_arbiter;
  logic        wr_clk = 1'b0;
  logic        rst = 1'b0;
  logic [3:0]  req_valid = '0;
  logic [31:0] req_data = '0;
  logic [3:0]  req_last = '0;
  logic [3:0]  req_ready;
  logic        full = 1'b0;
  logic        wr_error = 1'b0;
  logic        wr_en;
  logic [7:0]  wdata;
  logic [3:0]  grant;
  logic        busy;
  logic [15:0] err_cnt;
  logic        err_clr = 1'b0;

  int n_vec = 0;
  int n_err = 0;
  logic [7:0] exp_q[$];
  logic       sb_on = 1'b0;

  async_fifo_wr_arbiter #(
    .WIDTH(8), .NUM_REQ(4), .MAX_BURST(4), .ERR_CNT_W(16)
  ) dut (
    .wr_clk_i    (wr_clk),
    .rst_i       (rst),
    .req_valid_i (req_valid),
    .req_data_i  (req_data),
    .req_last_i  (req_last),
    .req_ready_o (req_ready),
    .full_i      (full),
    .wr_error_i  (wr_error),
    .wr_en_o     (wr_en),
    .wdata_o     (wdata),
    .grant_o     (grant),
    .busy_o      (busy),
    .err_cnt_o   (err_cnt),
    .err_clr_i   (err_clr)
  );

  // clock / reset
  always #5 wr_clk = ~wr_clk;

  initial begin
    #2_000_000;
    $display("FAIL timeout: run did not finish, got running expected finished");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // driver tasks
  task automatic step();
    @(posedge wr_clk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic set_data(input int k, input logic [7:0] v);
    req_data[k*8 +: 8] = v;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    req_valid = '0;
    req_last = '0;
    full = 1'b0;
    wr_error = 1'b0;
    err_clr = 1'b0;
    #1;
    step();
    step();
    rst = 1'b1;
    step();
  endtask

  // scoreboard and invariants, sampled on the falling edge
  always @(negedge wr_clk) begin
    if (rst) begin
      check("inv_grant_onehot", 32'($onehot0(grant)), 32'd1);
      check("inv_ready_onehot", 32'($onehot0(req_ready)), 32'd1);
      check("inv_wr_full", 32'(wr_en & full), 32'd0);
      check("inv_wr_busy", 32'(wr_en & ~busy), 32'd0);
    end
    if (sb_on && wr_en) begin
      if (exp_q.size() == 0) check("sb_underflow", 32'd1, 32'd0);
      else check("sb_data", 32'(wdata), 32'(exp_q.pop_front()));
    end
  end

  initial begin
    // 1. reset with all requesters valid
    req_valid = 4'b1111;
    step();
    step();
    check("rst_grant", 32'(grant), 32'h0);
    check("rst_wr_en", 32'(wr_en), 32'h0);
    check("rst_ready", 32'(req_ready), 32'h0);
    check("rst_err_cnt", 32'(err_cnt), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    rst = 1'b1;
    settle();
    check("rel_idle_wr_en", 32'(wr_en), 32'h0);
    step();
    check("rel_first_grant", 32'(grant), 32'h1);
    do_reset();

    // 2. single burst from req0 terminated by last
    req_valid = 4'b0001;
    set_data(0, 8'h11);
    settle();
    check("b_idle_wr_en", 32'(wr_en), 32'h0);
    step();
    check("b_ready0", 32'(req_ready), 32'h1);
    check("b_wr_en0", 32'(wr_en), 32'h1);
    check("b_data0", 32'(wdata), 32'h11);
    step();
    set_data(0, 8'h22);
    settle();
    check("b_wr_en1", 32'(wr_en), 32'h1);
    check("b_data1", 32'(wdata), 32'h22);
    step();
    set_data(0, 8'h33);
    req_last = 4'b0001;
    settle();
    check("b_wr_en2", 32'(wr_en), 32'h1);
    check("b_data2", 32'(wdata), 32'h33);
    step();
    req_valid = '0;
    req_last = '0;
    settle();
    check("b_end_grant", 32'(grant), 32'h0);
    check("b_end_busy", 32'(busy), 32'h0);
    check("b_end_wr_en", 32'(wr_en), 32'h0);

    // 3. round robin with MAX_BURST release
    do_reset();
    for (int k = 0; k < 4; k++) set_data(k, 8'(8'hA0 + k));
    req_valid = 4'b1111;
    for (int g = 0; g < 5; g++) begin
      settle();
      check("rr_bubble_grant", 32'(grant), 32'h0);
      check("rr_bubble_wr_en", 32'(wr_en), 32'h0);
      step();
      for (int b = 0; b < 4; b++) begin
        settle();
        check("rr_grant", 32'(grant), 32'(4'b0001 << (g % 4)));
        check("rr_wr_en", 32'(wr_en), 32'h1);
        check("rr_data", 32'(wdata), 32'(8'hA0 + (g % 4)));
        step();
      end
    end
    req_valid = '0;
    step();

    // 4. back-pressure on req1 mid-burst
    sb_on = 1'b1;
    exp_q.push_back(8'h41);
    exp_q.push_back(8'h42);
    exp_q.push_back(8'h43);
    exp_q.push_back(8'h44);
    req_valid = 4'b0010;
    set_data(1, 8'h41);
    settle();
    check("bp_idle_grant", 32'(grant), 32'h0);
    step();
    check("bp_grant", 32'(grant), 32'h2);
    check("bp_wr_en1", 32'(wr_en), 32'h1);
    step();
    set_data(1, 8'h42);
    settle();
    check("bp_wr_en2", 32'(wr_en), 32'h1);
    step();
    set_data(1, 8'h43);
    full = 1'b1;
    for (int c = 0; c < 3; c++) begin
      settle();
      check("bp_full_ready", 32'(req_ready), 32'h0);
      check("bp_full_wr_en", 32'(wr_en), 32'h0);
      check("bp_full_grant", 32'(grant), 32'h2);
      step();
    end
    full = 1'b0;
    settle();
    check("bp_wr_en3", 32'(wr_en), 32'h1);
    check("bp_data3", 32'(wdata), 32'h43);
    step();
    set_data(1, 8'h44);
    settle();
    check("bp_wr_en4", 32'(wr_en), 32'h1);
    check("bp_data4", 32'(wdata), 32'h44);
    step();
    req_valid = '0;
    settle();
    check("bp_end_grant", 32'(grant), 32'h0);
    step();
    sb_on = 1'b0;
    check("sb_drain", 32'(exp_q.size()), 32'd0);

    // 5. error counter: count, clear priority, saturation
    wr_error = 1'b1;
    repeat (5) step();
    wr_error = 1'b0;
    settle();
    check("err_five", 32'(err_cnt), 32'd5);
    wr_error = 1'b1;
    err_clr = 1'b1;
    step();
    wr_error = 1'b0;
    err_clr = 1'b0;
    settle();
    check("err_clr_prio", 32'(err_cnt), 32'd0);
    wr_error = 1'b1;
    repeat (65534) step();
    check("err_fffe", 32'(err_cnt), 32'hFFFE);
    step();
    check("err_ffff", 32'(err_cnt), 32'hFFFF);
    step();
    check("err_sat", 32'(err_cnt), 32'hFFFF);
    step();
    check("err_sat2", 32'(err_cnt), 32'hFFFF);
    wr_error = 1'b0;
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    check("err_clr_sat", 32'(err_cnt), 32'd0);
    wr_error = 1'b1;
    repeat (3) step();
    wr_error = 1'b0;
    check("err_three", 32'(err_cnt), 32'd3);

    // 6. reset mid-burst on req2 (rr_ptr is 2 here)
    req_valid = 4'b0100;
    set_data(2, 8'h61);
    step();
    check("mr_grant", 32'(grant), 32'h4);
    check("mr_wr_en1", 32'(wr_en), 32'h1);
    step();
    set_data(2, 8'h62);
    settle();
    check("mr_wr_en2", 32'(wr_en), 32'h1);
    step();
    rst = 1'b0;
    #1;
    check("mr_async_grant", 32'(grant), 32'h0);
    check("mr_async_busy", 32'(busy), 32'h0);
    check("mr_async_wr_en", 32'(wr_en), 32'h0);
    check("mr_async_err", 32'(err_cnt), 32'h0);
    step();
    rst = 1'b1;
    req_valid = 4'b1111;
    settle();
    check("mr_idle_grant", 32'(grant), 32'h0);
    step();
    check("mr_restart_grant", 32'(grant), 32'h1);
    req_valid = '0;
    repeat (3) step();
    check("mr_hold_grant", 32'(grant), 32'h1);
    check("mr_hold_busy", 32'(busy), 32'h1);
    check("mr_hold_wr_en", 32'(wr_en), 32'h0);

    // final report
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
